// File: rtl/cpu_pkg.sv
// Shared constants for the cpu_mc_v2 core: opcodes, condition codes, FSM
// states, special register codes, flag bit positions and status codes.
package cpu_pkg;

  localparam logic [4:0] OPC_LOAD  = 5'h01;
  localparam logic [4:0] OPC_STORE = 5'h02;
  localparam logic [4:0] OPC_AND   = 5'h03;
  localparam logic [4:0] OPC_OR    = 5'h04;
  localparam logic [4:0] OPC_XOR   = 5'h05;
  localparam logic [4:0] OPC_ADD   = 5'h06;
  localparam logic [4:0] OPC_ADDC  = 5'h07;
  localparam logic [4:0] OPC_SUB   = 5'h08;
  localparam logic [4:0] OPC_MUL   = 5'h09;
  localparam logic [4:0] OPC_DIV   = 5'h0A;
  localparam logic [4:0] OPC_SDIV  = 5'h0B;
  localparam logic [4:0] OPC_HALT  = 5'h1F;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_NEVER  = 3'd1;
  localparam logic [2:0] COND_Z      = 3'd2;
  localparam logic [2:0] COND_NZ     = 3'd3;
  localparam logic [2:0] COND_GE     = 3'd4;
  localparam logic [2:0] COND_LT     = 3'd5;

  localparam logic [2:0] ST_FLUSH     = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_MEMWAIT   = 3'd4;
  localparam logic [2:0] ST_WRITEBACK = 3'd5;
  localparam logic [2:0] ST_HALT      = 3'd6;

  localparam logic [3:0] REG_PC  = 4'd14;
  localparam logic [3:0] REG_OVF = 4'd15;

  localparam int FLAG_Z  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_GE = 2;

  localparam logic [7:0] STAT_RUN     = 8'h01;
  localparam logic [7:0] STAT_FLUSH   = 8'h02;
  localparam logic [7:0] STAT_HALT    = 8'h04;
  localparam logic [7:0] STAT_MEMWAIT = 8'h08;

  // Rb occupies the top four bits of the immediate field.
  typedef struct packed {
    logic        imb;
    logic [3:0]  ra;
    logic [13:0] imm;
    logic [4:0]  opc;
    logic [3:0]  rc;
    logic [2:0]  cond;
    logic        cmp;
  } instr_t;

  function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] flags);
    case (cond)
      COND_ALWAYS: return 1'b1;
      COND_NEVER:  return 1'b0;
      COND_Z:      return flags[FLAG_Z];
      COND_NZ:     return !flags[FLAG_Z];
      COND_GE:     return flags[FLAG_GE];
      COND_LT:     return !flags[FLAG_GE];
      default:     return 1'b1;
    endcase
  endfunction

  function automatic logic is_alu_op(input logic [4:0] opc);
    return (opc >= OPC_AND) && (opc <= OPC_SDIV);
  endfunction

endpackage

// File: rtl/cpu_mc_v2_if.sv
// Data-memory request/acknowledge bus between the core (master) and the
// RAM/peripheral fabric (slave).
interface cpu_mc_v2_if #(
  parameter int DATA_W  = 32,
  parameter int DADDR_W = 14
);
  logic [DADDR_W-1:0] dataAddress;
  logic [DATA_W-1:0]  dataOut;
  logic [DATA_W-1:0]  dataIn;
  logic               dataReq;
  logic               dataWrEn;
  logic               dataAck;

  modport master (
    output dataAddress, dataOut, dataReq, dataWrEn,
    input  dataIn, dataAck
  );

  modport slave (
    input  dataAddress, dataOut, dataReq, dataWrEn,
    output dataIn, dataAck
  );
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: logic ops, add/sub with carry, widening multiply and
// unsigned/signed divide. The second output word carries the MUL high half
// or the divide remainder.
module cpu_alu import cpu_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        opc,
  input  logic              carry_in,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] ovf_word,
  output logic [2:0]        flags
);

  logic                  carry;
  logic [2*DATA_W-1:0]   prod;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    result   = '0;
    ovf_word = '0;
    carry    = 1'b0;
    prod     = '0;
    case (opc)
      OPC_AND:  result = a & b;
      OPC_OR:   result = a | b;
      OPC_XOR:  result = a ^ b;
      OPC_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
      OPC_ADDC: {carry, result} = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, carry_in};
      // C after SUB is the borrow out of the top bit.
      OPC_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
      OPC_MUL: begin
        prod     = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        result   = prod[DATA_W-1:0];
        ovf_word = prod[2*DATA_W-1:DATA_W];
      end
      OPC_DIV: begin
        if (b == '0) begin
          result   = '1;
          ovf_word = a;
        end else begin
          result   = a / b;
          ovf_word = a % b;
        end
      end
      OPC_SDIV: begin
        if (b == '0) begin
          result   = '1;
          ovf_word = a;
        end else begin
          result   = $signed(a) / $signed(b);
          ovf_word = $signed(a) % $signed(b);
        end
      end
      default: ;
    endcase
    flags[FLAG_Z]  = (result == '0);
    flags[FLAG_C]  = carry;
    flags[FLAG_GE] = ($signed(a) >= $signed(b));
  end

endmodule

// File: rtl/cpu_mc_v2.sv
// Multi-cycle CPU core: FETCH/DECODE/EXECUTE/{MEMWAIT}/WRITEBACK sequencer,
// register file, flags and the req/ack data-memory handshake.
module cpu_mc_v2 import cpu_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 12,
  parameter int DADDR_W = 14,
  parameter int NREG    = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instructionIn,
  output logic [PC_W-1:0]   instructionAddress,
  cpu_mc_v2_if.master       dbus,
  output logic [7:0]        cpuStatus,
  output logic              halted
);

  logic [2:0]         state;
  logic [PC_W-1:0]    pc;
  logic [DATA_W-1:0]  regs [NREG];
  logic [DATA_W-1:0]  ovf;
  logic [2:0]         flags;
  instr_t             ir;
  logic [DATA_W-1:0]  a_val, b_val, load_data;
  logic               exec_ok;

  logic               mem_req, mem_we;
  logic [DADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_wdata;

  logic [DATA_W-1:0]  a_rd, b_rd, alu_result, alu_ovf, wb_val;
  logic [2:0]         alu_flags;
  logic [3:0]         rb;
  logic               cond_ok, is_mem, wr_rc, ovf_wr;
  logic [DADDR_W-1:0] load_addr;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a        (a_val),
    .b        (b_val),
    .opc      (ir.opc),
    .carry_in (flags[FLAG_C]),
    .result   (alu_result),
    .ovf_word (alu_ovf),
    .flags    (alu_flags)
  );

  assign rb = ir.imm[13:10];

  // Operand read: Ra 14/15 expose pc and overflow, unimplemented codes read 0.
  always_comb begin
    a_rd = '0;
    if (ir.ra == REG_PC)
      a_rd = DATA_W'(pc);
    else if (ir.ra == REG_OVF)
      a_rd = ovf;
    else if (int'(ir.ra) < NREG)
      a_rd = regs[ir.ra];

    b_rd = '0;
    if (ir.imb)
      b_rd = {{(DATA_W-14){ir.imm[13]}}, ir.imm};
    else if (int'(rb) < NREG)
      b_rd = regs[rb];
  end

  assign cond_ok   = cond_true(ir.cond, flags);
  assign is_mem    = (ir.opc == OPC_LOAD) || (ir.opc == OPC_STORE);
  assign load_addr = a_val[DADDR_W-1:0] + b_val[DADDR_W-1:0];
  assign wb_val    = (ir.opc == OPC_LOAD) ? load_data : alu_result;
  assign wr_rc     = exec_ok && ((ir.opc == OPC_LOAD) || is_alu_op(ir.opc));
  assign ovf_wr    = exec_ok && (ir.rc != REG_OVF) &&
                     ((ir.opc == OPC_MUL) || (ir.opc == OPC_DIV) || (ir.opc == OPC_SDIV));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FLUSH;
      pc        <= '0;
      ovf       <= '0;
      flags     <= '0;
      ir        <= '0;
      a_val     <= '0;
      b_val     <= '0;
      load_data <= '0;
      exec_ok   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      // NOTE: the register file is architecturally cleared on reset, so it is
      // built from flops rather than a RAM macro.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        ST_FLUSH: state <= ST_FETCH;
        ST_FETCH: begin
          ir    <= instructionIn;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          a_val <= a_rd;
          b_val <= b_rd;
          state <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          exec_ok <= cond_ok;
          if (ir.opc == OPC_HALT) begin
            state <= ST_HALT;
          end else if (is_mem && cond_ok) begin
            mem_req <= 1'b1;
            if (ir.opc == OPC_STORE) begin
              mem_we    <= 1'b1;
              mem_addr  <= b_val[DADDR_W-1:0];
              mem_wdata <= a_val;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= load_addr;
            end
            state <= ST_MEMWAIT;
          end else begin
            state <= ST_WRITEBACK;
          end
        end
        ST_MEMWAIT: begin
          if (dbus.dataAck) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (ir.opc == OPC_LOAD) load_data <= dbus.dataIn;
            state <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          if (ir.cmp) flags <= alu_flags;
          if (ovf_wr) ovf <= alu_ovf;
          if (wr_rc && (int'(ir.rc) < NREG)) regs[ir.rc] <= wb_val;
          if (wr_rc && (ir.rc == REG_OVF)) ovf <= wb_val;
          if (wr_rc && (ir.rc == REG_PC)) begin
            pc    <= wb_val[PC_W-1:0];
            state <= ST_FLUSH;
          end else begin
            pc    <= pc + 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FLUSH;
      endcase
    end
  end

  always_comb begin
    case (state)
      ST_FLUSH:   cpuStatus = STAT_FLUSH;
      ST_MEMWAIT: cpuStatus = STAT_MEMWAIT;
      ST_HALT:    cpuStatus = STAT_HALT;
      default:    cpuStatus = STAT_RUN;
    endcase
  end

  assign halted             = (state == ST_HALT);
  assign instructionAddress = pc;
  assign dbus.dataReq       = mem_req;
  assign dbus.dataWrEn      = mem_we;
  assign dbus.dataAddress   = mem_addr;
  assign dbus.dataOut       = mem_wdata;

endmodule

// File: tb/tb_cpu_mc_v2.sv
// Directed bench for cpu_mc_v2: a combinational ROM program plus an inline
// memory responder, with hand-computed expectations checked by assertions.
module tb_cpu_mc_v2;

  localparam int DATA_W  = 32;
  localparam int PC_W    = 12;
  localparam int DADDR_W = 14;
  localparam int NREG    = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       instruction_in;
  logic [PC_W-1:0]   instruction_address;
  logic [7:0]        cpu_status;
  logic              halted;
  logic [31:0]       rom [0:4095];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic req_seen = 1'b0;

  cpu_mc_v2_if #(.DATA_W(DATA_W), .DADDR_W(DADDR_W)) dbus ();

  cpu_mc_v2 #(.DATA_W(DATA_W), .PC_W(PC_W), .DADDR_W(DADDR_W), .NREG(NREG)) dut (
    .clk                (clk),
    .rst                (rst),
    .instructionIn      (instruction_in),
    .instructionAddress (instruction_address),
    .dbus               (dbus),
    .cpuStatus          (cpu_status),
    .halted             (halted)
  );

  assign instruction_in = rom[instruction_address];

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ins_i(input int ra, input int imm, input int opc,
                                        input int rc, input int cond, input int cmp);
    return {1'b1, 4'(ra), 14'(imm), 5'(opc), 4'(rc), 3'(cond), 1'(cmp)};
  endfunction

  function automatic logic [31:0] ins_r(input int ra, input int rb, input int opc,
                                        input int rc, input int cond, input int cmp);
    return {1'b0, 4'(ra), 4'(rb), 10'd0, 5'(opc), 4'(rc), 3'(cond), 1'(cmp)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (dbus.dataReq === 1'b1) req_seen = 1'b1;
  endtask

  task automatic wait_pc(input logic [PC_W-1:0] target, input string tag);
    int n = 0;
    while (instruction_address !== target && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(instruction_address), 32'(target));
  endtask

  // Waits for a request, checks it stays stable for waits+1 cycles, then acks.
  task automatic mem_txn(input string tag, input logic we, input logic [DADDR_W-1:0] addr,
                         input logic chk_data, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rdata);
    int n = 0;
    while (dbus.dataReq !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, " status"}, 32'(cpu_status), 32'h08);
    for (int k = 0; k <= waits; k++) begin
      if (k > 0) tick();
      check({tag, " req"}, 32'(dbus.dataReq), 32'd1);
      check({tag, " wren"}, 32'(dbus.dataWrEn), 32'(we));
      check({tag, " addr"}, 32'(dbus.dataAddress), 32'(addr));
      if (chk_data) check({tag, " wdata"}, dbus.dataOut, wdata);
    end
    dbus.dataIn  = rdata;
    dbus.dataAck = 1'b1;
    tick();
    dbus.dataAck = 1'b0;
    dbus.dataIn  = '0;
    check({tag, " release"}, {30'd0, dbus.dataReq, dbus.dataWrEn}, 32'd0);
  endtask

  initial begin
    int   t;
    logic hold_ok;

    dbus.dataAck = 1'b0;
    dbus.dataIn  = '0;
    for (int i = 0; i < 4096; i++) rom[i] = 32'h0;

    rom[0]     = ins_i(0, 5, 'h06, 1, 0, 0);          // r1 = 5
    rom[1]     = ins_i(1, -3, 'h06, 2, 0, 0);         // r2 = r1 - 3 = 2
    rom[2]     = ins_i(2, 'h20, 'h02, 0, 0, 0);       // store r2 -> 0x20
    rom[3]     = ins_i(0, 'h1234, 'h06, 1, 0, 0);     // r1 = 0x1234
    rom[4]     = ins_i(1, 'h10, 'h02, 0, 0, 0);       // store r1 -> 0x10
    rom[5]     = ins_i(0, 'h10, 'h01, 3, 0, 0);       // r3 = mem[0x10]
    rom[6]     = ins_i(3, 'h30, 'h02, 0, 0, 0);       // store r3 -> 0x30
    rom[7]     = ins_i(0, 7, 'h06, 4, 0, 0);          // r4 = 7
    rom[8]     = ins_i(4, 7, 'h08, 5, 0, 1);          // r5 = r4 - 7, set flags
    rom[9]     = ins_i(0, 'h20, 'h06, 14, 2, 0);      // if Z: pc = 0x20
    rom['h20]  = ins_i(4, 7, 'h08, 5, 0, 1);          // Z again
    rom['h21]  = ins_i(0, 'h40, 'h06, 14, 3, 0);      // if !Z: pc = 0x40 (not taken)
    rom['h22]  = ins_i(0, 'h100, 'h06, 6, 0, 0);      // r6 = 0x100
    rom['h23]  = ins_i(6, 'h100, 'h09, 6, 0, 0);      // r6 = 0x10000
    rom['h24]  = ins_r(6, 6, 'h09, 7, 0, 0);          // r7 = low(2^32) = 0, ovf = 1
    rom['h25]  = ins_i(7, 'h40, 'h02, 0, 0, 0);       // store r7
    rom['h26]  = ins_i(15, 'h41, 'h02, 0, 0, 0);      // store overflow
    rom['h27]  = ins_i(0, 7, 'h06, 8, 0, 0);          // r8 = 7
    rom['h28]  = ins_r(8, 0, 'h0A, 9, 0, 0);          // r9 = 7 / 0
    rom['h29]  = ins_i(9, 'h42, 'h02, 0, 0, 0);       // store r9
    rom['h2A]  = ins_i(15, 'h43, 'h02, 0, 0, 0);      // store overflow
    rom['h2B]  = ins_i(0, 0, 'h1F, 0, 0, 0);          // halt

    tick();
    tick();
    check("rst dataReq", 32'(dbus.dataReq), 32'd0);
    check("rst dataWrEn", 32'(dbus.dataWrEn), 32'd0);
    check("rst dataAddress", 32'(dbus.dataAddress), 32'd0);
    check("rst dataOut", dbus.dataOut, 32'd0);
    check("rst status", 32'(cpu_status), 32'h02);
    check("rst halted", 32'(halted), 32'd0);
    check("rst pc", 32'(instruction_address), 32'd0);

    rst = 1'b0;
    t = cyc;
    req_seen = 1'b0;
    wait_pc(1, "add1 pc");
    check("add1 latency", 32'(cyc - t), 32'd5);
    t = cyc;
    wait_pc(2, "add2 pc");
    check("add2 latency", 32'(cyc - t), 32'd4);
    check("no req during alu", 32'(req_seen), 32'd0);

    mem_txn("st_r2", 1'b1, 14'h20, 1'b1, 32'd2, 0, 32'd0);
    wait_pc(3, "st_r2 pc");
    wait_pc(4, "add3 pc");
    t = cyc;
    mem_txn("st_r1", 1'b1, 14'h10, 1'b1, 32'h1234, 3, 32'd0);
    wait_pc(5, "st_r1 pc");
    check("st_r1 latency", 32'(cyc - t), 32'd8);

    t = cyc;
    mem_txn("ld_r3", 1'b0, 14'h10, 1'b0, 32'd0, 0, 32'hCAFE);
    wait_pc(6, "ld_r3 pc");
    check("ld_r3 latency", 32'(cyc - t), 32'd5);
    mem_txn("st_r3", 1'b1, 14'h30, 1'b1, 32'hCAFE, 0, 32'd0);
    wait_pc(7, "st_r3 pc");

    wait_pc(8, "add r4 pc");
    wait_pc(9, "sub pc");
    t = cyc;
    wait_pc('h20, "jz pc");
    check("jz latency", 32'(cyc - t), 32'd4);
    check("jz flush status", 32'(cpu_status), 32'h02);
    t = cyc;
    wait_pc('h21, "sub2 pc");
    check("post-flush latency", 32'(cyc - t), 32'd5);
    t = cyc;
    wait_pc('h22, "jnz pc");
    check("jnz latency", 32'(cyc - t), 32'd4);
    check("jnz status", 32'(cpu_status), 32'h01);

    wait_pc('h25, "mul pc");
    mem_txn("st_mul_lo", 1'b1, 14'h40, 1'b1, 32'd0, 0, 32'd0);
    wait_pc('h26, "st_mul_lo pc");
    mem_txn("st_mul_hi", 1'b1, 14'h41, 1'b1, 32'd1, 0, 32'd0);
    wait_pc('h27, "st_mul_hi pc");
    wait_pc('h29, "div pc");
    mem_txn("st_div_q", 1'b1, 14'h42, 1'b1, 32'hFFFF_FFFF, 0, 32'd0);
    wait_pc('h2A, "st_div_q pc");
    mem_txn("st_div_r", 1'b1, 14'h43, 1'b1, 32'd7, 0, 32'd0);
    wait_pc('h2B, "halt pc");

    tick();
    tick();
    tick();
    check("halt halted", 32'(halted), 32'd1);
    check("halt status", 32'(cpu_status), 32'h04);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (instruction_address !== 12'h2B || halted !== 1'b1 || cpu_status !== 8'h04)
        hold_ok = 1'b0;
    end
    check("halt hold 20 cycles", 32'(hold_ok), 32'd1);

    rom[0] = ins_i(0, 'h55, 'h06, 1, 0, 0);           // r1 = 0x55
    rom[1] = ins_i(1, 5, 'h02, 0, 0, 0);              // store r1 -> 5, never acked
    rst = 1'b1;
    tick();
    check("rst2 halted", 32'(halted), 32'd0);
    rst = 1'b0;
    begin
      int n = 0;
      while (dbus.dataReq !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
    end
    check("run2 req", 32'(dbus.dataReq), 32'd1);
    check("run2 wren", 32'(dbus.dataWrEn), 32'd1);
    check("run2 wdata", dbus.dataOut, 32'h55);
    tick();
    tick();
    check("run2 still waiting", 32'(cpu_status), 32'h08);
    rst = 1'b1;
    #1;
    check("async rst dataReq", 32'(dbus.dataReq), 32'd0);
    check("async rst dataWrEn", 32'(dbus.dataWrEn), 32'd0);
    check("async rst status", 32'(cpu_status), 32'h02);
    check("async rst dataAddress", 32'(dbus.dataAddress), 32'd0);
    check("async rst dataOut", dbus.dataOut, 32'd0);
    check("async rst pc", 32'(instruction_address), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
